keypad_digit_capture: RTL

Sits directly downstream of the keypad scanner. Consumes the scanner's row/column snapshot, its per-press decode strobe and its any-column-active level. Validates and debounces each press, then decodes it to a hex digit. Accepted digits shift into a two-digit history (newest, previous) that drives the dual seven-segment display mux, one digit per physical press.

---
 rtl/keypad_digit_capture_if.sv | 22 ++
 rtl/keypad_digit_capture.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/keypad_digit_capture_if.sv
// Scanner-to-capture bundle: the snapshot, decode strobe and column-activity
// level from the keypad scanner plus the digit history and status pulses back.
interface keypad_digit_capture_if;
  logic [7:0] keypad_val;
  logic       en;
  logic       button_on;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic       new_digit;
  logic       key_held;
  logic       bad_code;

  modport master (
    output keypad_val, en, button_on,
    input  digit_new, digit_old, new_digit, key_held, bad_code
  );

  modport slave (
    input  keypad_val, en, button_on,
    output digit_new, digit_old, new_digit, key_held, bad_code
  );
endinterface

// File: rtl/keypad_digit_capture.sv
// Validates, debounces and decodes one keypad press per physical press, and
// shifts accepted digits into a two-digit history for the seven-segment mux.
module keypad_digit_capture #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int RELEASE_CYCLES  = 20000
) (
  input logic                  clk,
  input logic                  reset,
  keypad_digit_capture_if.slave bus
);

  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > RELEASE_CYCLES) ? DEBOUNCE_CYCLES : RELEASE_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] deb_q, deb_d;
  logic [CNT_W-1:0] rel_q, rel_d;
  logic [7:0]       code_q, code_d;
  logic [3:0]       digit_new_q, digit_new_d;
  logic [3:0]       digit_old_q, digit_old_d;
  logic             new_digit_q, new_digit_d;
  logic             key_held_q, key_held_d;
  logic             bad_code_q, bad_code_d;
  logic             match;

  function automatic logic code_valid(input logic [7:0] code);
    return ($countones(code[7:4]) == 1) && ($countones(code[3:0]) == 1);
  endfunction

  // Row index comes from bits [7:4] (R0 is bit 7), column from [3:0] (C0 is bit 3).
  function automatic logic [3:0] decode(input logic [7:0] code);
    logic [1:0] row;
    logic [1:0] col;
    logic [3:0] digit;
    row   = 2'd0;
    col   = 2'd0;
    digit = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (code[7-i]) row = 2'(i);
      if (code[3-i]) col = 2'(i);
    end
    case ({row, col})
      4'd0:  digit = 4'h1;
      4'd1:  digit = 4'h2;
      4'd2:  digit = 4'h3;
      4'd3:  digit = 4'hA;
      4'd4:  digit = 4'h4;
      4'd5:  digit = 4'h5;
      4'd6:  digit = 4'h6;
      4'd7:  digit = 4'hB;
      4'd8:  digit = 4'h7;
      4'd9:  digit = 4'h8;
      4'd10: digit = 4'h9;
      4'd11: digit = 4'hC;
      4'd12: digit = 4'hE;
      4'd13: digit = 4'h0;
      4'd14: digit = 4'hF;
      4'd15: digit = 4'hD;
    endcase
    return digit;
  endfunction

  assign match = bus.button_on && (bus.keypad_val == code_q);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d     = state_q;
    deb_d       = deb_q;
    rel_d       = rel_q;
    code_d      = code_q;
    digit_new_d = digit_new_q;
    digit_old_d = digit_old_q;
    new_digit_d = 1'b0;
    bad_code_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.en) begin
          if (code_valid(bus.keypad_val)) begin
            code_d  = bus.keypad_val;
            deb_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            bad_code_d = 1'b1;
          end
        end
      end
      DEBOUNCE: begin
        if (!match) begin
          state_d = IDLE;
        end else if (deb_q == DEB_LAST) begin
          digit_old_d = digit_new_q;
          digit_new_d = decode(code_q);
          new_digit_d = 1'b1;
          rel_d       = '0;
          state_d     = HELD;
        end else if (deb_q != CNT_MAX) begin
          deb_d = deb_q + 1'b1;
        end
      end
      HELD: begin
        // A short release glitch only restarts the count; capture stays disarmed.
        if (bus.button_on) begin
          rel_d = '0;
        end else if (rel_q == REL_LAST) begin
          state_d = IDLE;
        end else if (rel_q != CNT_MAX) begin
          rel_d = rel_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    key_held_d = (state_d == HELD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      deb_q       <= '0;
      rel_q       <= '0;
      code_q      <= '0;
      digit_new_q <= '0;
      digit_old_q <= '0;
      new_digit_q <= 1'b0;
      key_held_q  <= 1'b0;
      bad_code_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_q       <= deb_d;
      rel_q       <= rel_d;
      code_q      <= code_d;
      digit_new_q <= digit_new_d;
      digit_old_q <= digit_old_d;
      new_digit_q <= new_digit_d;
      key_held_q  <= key_held_d;
      bad_code_q  <= bad_code_d;
    end
  end

  assign bus.digit_new = digit_new_q;
  assign bus.digit_old = digit_old_q;
  assign bus.new_digit = new_digit_q;
  assign bus.key_held  = key_held_q;
  assign bus.bad_code  = bad_code_q;

endmodule
